spi_vcmd_rx: RTL and testbench

- Serial front end of the video command path: SPI slave receiver (mode 0, MSB first, CSel active low) feeding a byte-stream command decoder.
- Decoded pixel bytes are presented with a frame-memory address, colour-channel index and ready strobe for the frame-buffer write port.
- Entire block runs on the SPI clock Sclk; no other clock.

---
 rtl/spi_vcmd_rx.sv | 123 ++++++++++++
 tb/tb_spi_vcmd_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_vcmd_rx.sv
// SPI mode-0 slave receiver feeding a video command decoder (NOP / WRITE pixels / SETADDR).
// Decoded bytes are presented on the edge that completes them; nothing can stall the serial stream.
module spi_vcmd_rx #(
    parameter int ADDR_WIDTH      = 18,
    parameter int BYTES_PER_PIXEL = 3
) (
    input  logic                  Sclk,
    input  logic                  Reset,
    input  logic                  Mosi,
    input  logic                  CSel,
    output logic                  ByteRecv,
    output logic [7:0]            ByteOut,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [7:0]            DataOut,
    output logic [1:0]            DataIndex,
    output logic                  DataRdy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_PIXEL
    } state_t;

    localparam logic [1:0]            LAST_CHAN = 2'(BYTES_PER_PIXEL - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    state_t                r_state;
    logic [2:0]            r_bit_cnt;
    logic [6:0]            r_shift;
    logic [15:0]           r_addr_buf;
    logic [1:0]            r_addr_idx;
    logic [6:0]            r_pix_cnt;
    logic [1:0]            r_chan;
    logic [ADDR_WIDTH-1:0] r_next_addr;

    logic [7:0]  w_byte;
    logic        w_byte_done;
    logic [23:0] w_addr_full;
    logic        w_unused_addr;

    assign w_byte      = {r_shift, Mosi};
    assign w_byte_done = !CSel && (r_bit_cnt == 3'd7);
    // Three SETADDR bytes concatenated; bits above ADDR_WIDTH are don't-care.
    assign w_addr_full   = {r_addr_buf, w_byte};
    assign w_unused_addr = ^w_addr_full[23:ADDR_WIDTH];

    always_ff @(posedge Sclk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            r_addr_buf  <= 16'd0;
            r_addr_idx  <= 2'd0;
            r_pix_cnt   <= 7'd0;
            r_chan      <= 2'd0;
            r_next_addr <= '0;
            ByteRecv    <= 1'b0;
            ByteOut     <= 8'd0;
            MemAddr     <= '0;
            DataOut     <= 8'd0;
            DataIndex   <= 2'd0;
            DataRdy     <= 1'b0;
        end else begin
            ByteRecv <= 1'b0;
            DataRdy  <= 1'b0;
            if (CSel) begin
                r_bit_cnt <= 3'd0;
                r_shift   <= 7'd0;
            end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= w_byte[6:0];
            end

            if (w_byte_done) begin
                ByteOut  <= w_byte;
                ByteRecv <= 1'b1;
                case (r_state)
                    ST_IDLE: begin
                        if (w_byte[7:6] == 2'b01) begin
                            r_pix_cnt <= (w_byte[5:0] == 6'd0) ? 7'd64 : {1'b0, w_byte[5:0]};
                            r_chan    <= 2'd0;
                            r_state   <= ST_PIXEL;
                        end else if (w_byte[7:6] == 2'b10) begin
                            r_addr_idx <= 2'd0;
                            r_state    <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (r_addr_idx == 2'd2) begin
                            r_next_addr <= w_addr_full[ADDR_WIDTH-1:0];
                            r_state     <= ST_IDLE;
                        end else begin
                            r_addr_buf <= {r_addr_buf[7:0], w_byte};
                            r_addr_idx <= r_addr_idx + 2'd1;
                        end
                    end
                    ST_PIXEL: begin
                        DataOut   <= w_byte;
                        DataIndex <= r_chan;
                        DataRdy   <= 1'b1;
                        // Address advances once per pixel, on its first channel byte.
                        if (r_chan == 2'd0) begin
                            MemAddr     <= r_next_addr;
                            r_next_addr <= r_next_addr + ADDR_ONE;
                        end
                        if (r_chan == LAST_CHAN) begin
                            r_chan    <= 2'd0;
                            r_pix_cnt <= r_pix_cnt - 7'd1;
                            if (r_pix_cnt == 7'd1) begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_chan <= r_chan + 2'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_vcmd_rx.sv
// Scoreboard bench for spi_vcmd_rx: stimulus pushes expected bytes/pixels, a negedge monitor pops and compares.
module tb_spi_vcmd_rx;

    localparam int AW = 18;

    logic          Sclk = 1'b0;
    logic          Reset;
    logic          Mosi;
    logic          CSel;
    logic          ByteRecv;
    logic [7:0]    ByteOut;
    logic [AW-1:0] MemAddr;
    logic [7:0]    DataOut;
    logic [1:0]    DataIndex;
    logic          DataRdy;

    spi_vcmd_rx #(.ADDR_WIDTH(AW), .BYTES_PER_PIXEL(3)) dut (
        .Sclk      (Sclk),
        .Reset     (Reset),
        .Mosi      (Mosi),
        .CSel      (CSel),
        .ByteRecv  (ByteRecv),
        .ByteOut   (ByteOut),
        .MemAddr   (MemAddr),
        .DataOut   (DataOut),
        .DataIndex (DataIndex),
        .DataRdy   (DataRdy)
    );

    always #10 Sclk = ~Sclk;

    typedef struct {
        logic          brecv;
        logic          drdy;
        logic [7:0]    bout;
        logic [7:0]    dout;
        logic [AW-1:0] maddr;
        logic [1:0]    didx;
    } snap_t;

    logic [7:0]           exp_byte_q[$];
    logic [AW+10-1:0]     exp_data_q[$];
    snap_t                snap_q[$];

    int checks = 0;
    int errors = 0;
    bit fin_req = 1'b0;
    bit fin_done = 1'b0;

    // Reference model state, owned by the stimulus process
    logic [AW-1:0] m_next = '0;
    logic [AW-1:0] m_cur  = '0;
    logic [1:0]    m_chan = 2'd0;

    always @(negedge Sclk) begin
        if (ByteRecv) begin
            checks++;
            if (exp_byte_q.size() == 0) begin
                errors++;
                $display("FAIL byte_unexpected got ByteOut=%02h, none expected", ByteOut);
            end else begin
                logic [7:0] eb;
                eb = exp_byte_q.pop_front();
                if (ByteOut !== eb) begin
                    errors++;
                    $display("FAIL byte_out got %02h want %02h", ByteOut, eb);
                end
            end
        end
        if (DataRdy) begin
            checks++;
            if (exp_data_q.size() == 0) begin
                errors++;
                $display("FAIL data_unexpected got addr=%05h data=%02h idx=%0d", MemAddr, DataOut, DataIndex);
            end else begin
                logic [AW+10-1:0] ed;
                ed = exp_data_q.pop_front();
                if ({MemAddr, DataOut, DataIndex} !== ed) begin
                    errors++;
                    $display("FAIL pixel got addr=%05h data=%02h idx=%0d want addr=%05h data=%02h idx=%0d",
                             MemAddr, DataOut, DataIndex, ed[AW+9:10], ed[9:2], ed[1:0]);
                end
            end
        end
        if (snap_q.size() != 0) begin
            snap_t s;
            s = snap_q.pop_front();
            checks++;
            if (ByteRecv !== s.brecv || DataRdy !== s.drdy || ByteOut !== s.bout ||
                DataOut !== s.dout || MemAddr !== s.maddr || DataIndex !== s.didx) begin
                errors++;
                $display("FAIL snapshot got br=%b dr=%b bo=%02h do=%02h ma=%05h di=%0d want br=%b dr=%b bo=%02h do=%02h ma=%05h di=%0d",
                         ByteRecv, DataRdy, ByteOut, DataOut, MemAddr, DataIndex,
                         s.brecv, s.drdy, s.bout, s.dout, s.maddr, s.didx);
            end
        end
        if (fin_req && !fin_done) begin
            checks++;
            if (exp_byte_q.size() != 0 || exp_data_q.size() != 0) begin
                errors++;
                $display("FAIL drain got bytes_left=%0d pixels_left=%0d want 0 0",
                         exp_byte_q.size(), exp_data_q.size());
            end
            fin_done = 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        exp_byte_q.push_back(b);
        for (int i = 7; i >= 0; i--) begin
            @(negedge Sclk);
            CSel = 1'b0;
            Mosi = b[i];
        end
        @(negedge Sclk);
        CSel = 1'b1;
        Mosi = 1'b0;
    endtask

    task automatic send_pix(input logic [7:0] b);
        if (m_chan == 2'd0) begin
            m_cur  = m_next;
            m_next = m_next + 1'b1;
        end
        exp_data_q.push_back({m_cur, b, m_chan});
        m_chan = (m_chan == 2'd2) ? 2'd0 : m_chan + 2'd1;
        send_byte(b);
    endtask

    task automatic set_addr(input logic [AW-1:0] a);
        logic [7:0] hi;
        hi = {6'd0, a[17:16]};
        send_byte(8'h80);
        send_byte(hi);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        m_next = a;
    endtask

    task automatic push_snap(input logic [7:0] bout, input logic [7:0] dout,
                             input logic [AW-1:0] maddr, input logic [1:0] didx);
        snap_t s;
        s.brecv = 1'b0;
        s.drdy  = 1'b0;
        s.bout  = bout;
        s.dout  = dout;
        s.maddr = maddr;
        s.didx  = didx;
        snap_q.push_back(s);
    endtask

    initial begin
        Reset = 1'b1;
        CSel  = 1'b1;
        Mosi  = 1'b0;
        repeat (3) @(posedge Sclk);
        #1;
        push_snap(8'h00, 8'h00, '0, 2'd0);
        @(negedge Sclk);
        Reset = 1'b0;

        // First write: one pixel at address 0
        send_byte(8'h41);
        for (int i = 0; i < 3; i++) send_pix(8'hC0);
        // Second write continues at address 1
        send_byte(8'h41);
        for (int i = 0; i < 3; i++) send_pix(8'h03);
        // SETADDR to top of memory, two pixels wrap to 0
        set_addr(18'h3FFFF);
        send_byte(8'h42);
        for (int i = 0; i < 6; i++) send_pix(8'(8'h10 + i));

        // Mid-byte abort: 4 bits then CSel high for one edge
        for (int i = 0; i < 4; i++) begin
            @(negedge Sclk);
            CSel = 1'b0;
            Mosi = (i != 1);
        end
        @(negedge Sclk);
        CSel = 1'b1;
        Mosi = 1'b0;
        send_byte(8'h41);
        send_pix(8'h55);

        // Reset in the middle of a pixel
        Reset = 1'b1;
        @(posedge Sclk);
        #1;
        push_snap(8'h00, 8'h00, '0, 2'd0);
        m_next = '0;
        m_chan = 2'd0;
        @(negedge Sclk);
        Reset = 1'b0;

        send_byte(8'hC0);
        send_byte(8'h41);
        send_pix(8'h21);
        send_pix(8'h22);
        send_pix(8'h23);
        send_byte(8'h00);
        send_byte(8'hC5);
        @(posedge Sclk);
        #1;
        push_snap(8'hC5, 8'h23, '0, 2'd2);

        // PixCnt 0 means 64 pixels
        send_byte(8'h40);
        for (int p = 0; p < 192; p++) send_pix(8'(p));
        send_byte(8'h41);
        for (int i = 0; i < 3; i++) send_pix(8'(8'hA0 + i));

        repeat (4) @(posedge Sclk);
        fin_req = 1'b1;
        for (int i = 0; i < 20 && !fin_done; i++) @(posedge Sclk);
        if (!fin_done) begin
            $display("FAIL drain_timeout got no drain check want drain check");
            $fatal(1, "drain timeout");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
